// File: rtl/timer_sched_ctrl.sv
// Compare-schedule sequencer: walks a table of absolute match values, one entry per timer match-0 event.
// Optional serviced-event counter is built only when TMR_SCHED_EVT_CNT_EN is defined.
module timer_sched_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 32,
    parameter int DEPTH      = 8,
    localparam int IW        = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          cfg_wr_en,
    input  logic [IW-1:0] cfg_wr_idx,
    input  logic [N-1:0]  cfg_wr_data,
    input  logic [IW-1:0] cfg_last_idx,
    input  logic          cfg_loop,
    input  logic          cmd_go,
    input  logic          cmd_abort,
    input  logic          tmr_match0_event,
    input  logic          tmr_ovf_event,
    output logic          tmr_rst,
    output logic          tmr_start,
    output logic          tmr_stop,
    output logic [N-1:0]  tmr_match_val0,
    output logic          tmr_match0_en,
    output logic          evt_out,
    output logic          done,
    output logic          err_ovf,
    output logic          busy,
    output logic [IW-1:0] seq_idx,
    output logic [N-1:0]  evt_cnt
);

    if (DATA_WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_chk
        $error("timer_sched_ctrl: DEPTH must be a power of two >= 2 and DATA_WIDTH >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] seq_idx_q, seq_idx_d;
    logic [N-1:0]  match_val_q, match_val_d;
    logic          tmr_rst_q, tmr_rst_d;
    logic          tmr_start_q, tmr_start_d;
    logic          tmr_stop_q, tmr_stop_d;
    logic          evt_q, evt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [N-1:0]  table_q [DEPTH];
    logic [IW-1:0] idx_inc;

    assign idx_inc = seq_idx_q + IW'(1);

    // Table is only writable while idle so a running schedule never sees a torn entry.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && cfg_wr_en && state_q == IDLE) begin
            table_q[cfg_wr_idx] <= cfg_wr_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        seq_idx_d   = seq_idx_q;
        match_val_d = match_val_q;
        tmr_rst_d   = 1'b0;
        tmr_start_d = 1'b0;
        tmr_stop_d  = 1'b0;
        evt_d       = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_go) begin
                    state_d     = ARM;
                    seq_idx_d   = '0;
                    match_val_d = table_q[0];
                    tmr_rst_d   = 1'b1;
                end
            end
            ARM: begin
                if (cmd_abort) begin
                    state_d    = IDLE;
                    tmr_stop_d = 1'b1;
                end else begin
                    state_d     = RUN;
                    tmr_start_d = 1'b1;
                end
            end
            RUN: begin
                if (cmd_abort) begin
                    state_d    = IDLE;
                    tmr_stop_d = 1'b1;
                end else if (tmr_ovf_event) begin
                    state_d    = IDLE;
                    tmr_stop_d = 1'b1;
                    err_d      = 1'b1;
                end else if (tmr_match0_event) begin
                    evt_d = 1'b1;
                    // An index already past a live-lowered last entry is treated as the end.
                    if (seq_idx_q < cfg_last_idx) begin
                        seq_idx_d   = idx_inc;
                        match_val_d = table_q[idx_inc];
                    end else if (cfg_loop) begin
                        seq_idx_d   = '0;
                        match_val_d = table_q[0];
                        tmr_rst_d   = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        tmr_stop_d = 1'b1;
                        done_d     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            seq_idx_q   <= '0;
            match_val_q <= '0;
            tmr_rst_q   <= 1'b0;
            tmr_start_q <= 1'b0;
            tmr_stop_q  <= 1'b0;
            evt_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_idx_q   <= seq_idx_d;
            match_val_q <= match_val_d;
            tmr_rst_q   <= tmr_rst_d;
            tmr_start_q <= tmr_start_d;
            tmr_stop_q  <= tmr_stop_d;
            evt_q       <= evt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef TMR_SCHED_EVT_CNT_EN
    logic [N-1:0] evt_cnt_q, evt_cnt_d;

    // Counts in step with evt_out so the final event of a one-shot lands before IDLE holds it.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (state_q == IDLE && cmd_go) begin
            evt_cnt_d = '0;
        end else if (evt_d && evt_cnt_q != '1) begin
            evt_cnt_d = evt_cnt_q + N'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign evt_cnt = evt_cnt_q;
`else
    assign evt_cnt = '0;
`endif

    assign busy           = (state_q != IDLE);
    assign tmr_match0_en  = (state_q != IDLE);
    assign tmr_rst        = tmr_rst_q;
    assign tmr_start      = tmr_start_q;
    assign tmr_stop       = tmr_stop_q;
    assign tmr_match_val0 = match_val_q;
    assign evt_out        = evt_q;
    assign done           = done_q;
    assign err_ovf        = err_q;
    assign seq_idx        = seq_idx_q;

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// Self-checking bench for timer_sched_ctrl: directed schedule scenarios plus random traffic
// checked every cycle against an event-count based reference model.
module tb_timer_sched_ctrl;

    localparam int N     = 32;
    localparam int DEPTH = 8;
    localparam int IW    = 3;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          cfg_wr_en;
    logic [IW-1:0] cfg_wr_idx;
    logic [N-1:0]  cfg_wr_data;
    logic [IW-1:0] cfg_last_idx;
    logic          cfg_loop;
    logic          cmd_go;
    logic          cmd_abort;
    logic          tmr_match0_event;
    logic          tmr_ovf_event;
    logic          tmr_rst;
    logic          tmr_start;
    logic          tmr_stop;
    logic [N-1:0]  tmr_match_val0;
    logic          tmr_match0_en;
    logic          evt_out;
    logic          done;
    logic          err_ovf;
    logic          busy;
    logic [IW-1:0] seq_idx;
    logic [N-1:0]  evt_cnt;

    timer_sched_ctrl #(.DATA_WIDTH(32), .N(N), .DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_data(cfg_wr_data),
        .cfg_last_idx(cfg_last_idx), .cfg_loop(cfg_loop),
        .cmd_go(cmd_go), .cmd_abort(cmd_abort),
        .tmr_match0_event(tmr_match0_event), .tmr_ovf_event(tmr_ovf_event),
        .tmr_rst(tmr_rst), .tmr_start(tmr_start), .tmr_stop(tmr_stop),
        .tmr_match_val0(tmr_match_val0), .tmr_match0_en(tmr_match0_en),
        .evt_out(evt_out), .done(done), .err_ovf(err_ovf), .busy(busy),
        .seq_idx(seq_idx), .evt_cnt(evt_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int totalCount = 0;
    int badCount   = 0;

    // Reference model: progress is tracked as cycles since go and number of matches served.
    logic [N-1:0]  mTable [DEPTH];
    int            mAge = 0;
    int            mServed = 0;
    logic [IW-1:0] mIdx = '0;
    logic [N-1:0]  mVal = '0;
    logic [N-1:0]  mCnt = '0;
    bit eRst, eStart, eStop, eEvt, eDone, eErr;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCount++;
        if (got !== exp) begin
            badCount++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelStep(input bit go, input bit abort, input bit m, input bit ovf, input bit rst,
                             input bit wrEn, input logic [IW-1:0] wIdx, input logic [N-1:0] wData);
        int span;
        span = int'(cfg_last_idx) + 1;
        {eRst, eStart, eStop, eEvt, eDone, eErr} = '0;
        if (rst) begin
            mAge = 0; mIdx = '0; mVal = '0; mCnt = '0;
        end else if (mAge == 0) begin
            if (go) begin
                mAge = 1; mServed = 0; mIdx = '0; mVal = mTable[0]; mCnt = '0; eRst = 1'b1;
            end
            if (wrEn) mTable[wIdx] = wData;
        end else if (mAge == 1) begin
            if (abort) begin eStop = 1'b1; mAge = 0; end
            else begin eStart = 1'b1; mAge = 2; end
        end else begin
            if (abort) begin
                eStop = 1'b1; mAge = 0;
            end else if (ovf) begin
                eStop = 1'b1; eErr = 1'b1; mAge = 0;
            end else if (m) begin
                eEvt = 1'b1;
                mServed++;
                if (mCnt != '1) mCnt = mCnt + 1;
                if (cfg_loop) begin
                    mIdx = IW'(mServed % span);
                    mVal = mTable[mIdx];
                    eRst = (mIdx == 0);
                end else if (mServed >= span) begin
                    eStop = 1'b1; eDone = 1'b1; mAge = 0;
                end else begin
                    mIdx = IW'(mServed);
                    mVal = mTable[mIdx];
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit go, input bit abort, input bit m, input bit ovf, input bit rst,
                                 input bit wrEn, input logic [IW-1:0] wIdx, input logic [N-1:0] wData);
        @(negedge sys_clk);
        cmd_go = go; cmd_abort = abort; tmr_match0_event = m; tmr_ovf_event = ovf;
        sys_rst = rst; cfg_wr_en = wrEn; cfg_wr_idx = wIdx; cfg_wr_data = wData;
        @(posedge sys_clk);
        modelStep(go, abort, m, ovf, rst, wrEn, wIdx, wData);
        #1;
        checkOutput("busy",      64'(busy),           64'(mAge > 0));
        checkOutput("match0_en", 64'(tmr_match0_en),  64'(mAge > 0));
        checkOutput("seq_idx",   64'(seq_idx),        64'(mIdx));
        checkOutput("match_val", 64'(tmr_match_val0), 64'(mVal));
        checkOutput("pulses",    64'({tmr_rst, tmr_start, tmr_stop, evt_out, done, err_ovf}),
                    64'({eRst, eStart, eStop, eEvt, eDone, eErr}));
`ifdef TMR_SCHED_EVT_CNT_EN
        checkOutput("evt_cnt",   64'(evt_cnt),        64'(mCnt));
`else
        checkOutput("evt_cnt",   64'(evt_cnt),        64'(0));
`endif
    endtask

    task automatic cyc(input bit go, input bit abort, input bit m, input bit ovf, input bit rst);
        applyStimulus(go, abort, m, ovf, rst, 1'b0, '0, '0);
    endtask

    initial begin
        sys_rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_data = '0;
        cfg_last_idx = 3'd2; cfg_loop = 1'b0; cmd_go = 1'b0; cmd_abort = 1'b0;
        tmr_match0_event = 1'b0; tmr_ovf_event = 1'b0;

        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        checkOutput("reset_busy", 64'(busy), 64'(0));
        cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < DEPTH; i++) begin
            logic [N-1:0] v;
            v = (i < 3) ? N'(100 * (i + 1)) : N'($urandom);
            applyStimulus(0, 0, 0, 0, 0, 1'b1, IW'(i), v);
        end

        // One-shot over three entries.
        cfg_last_idx = 3'd2; cfg_loop = 1'b0;
        cyc(1, 0, 0, 0, 0);
        checkOutput("os_arm_val", 64'(tmr_match_val0), 64'(100));
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        checkOutput("os_val1", 64'(tmr_match_val0), 64'(200));
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        checkOutput("os_val2", 64'(tmr_match_val0), 64'(300));
        cyc(0, 0, 1, 0, 0);
        checkOutput("os_done", 64'({done, tmr_stop, evt_out, busy}), 64'(4'b1110));

        // Looping schedule with back-to-back matches.
        cfg_loop = 1'b1;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0);
        checkOutput("loop_idx", 64'(seq_idx), 64'(1));
`ifdef TMR_SCHED_EVT_CNT_EN
        checkOutput("loop_cnt", 64'(evt_cnt), 64'(7));
`endif
        cyc(0, 1, 0, 0, 0);

        // Abort wins over a simultaneous match.
        cfg_loop = 1'b0;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        checkOutput("abort_pulses", 64'({tmr_stop, evt_out, done, busy}), 64'(4'b1000));

        // Overflow at seq_idx 1.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        checkOutput("ovf_pulses", 64'({err_ovf, tmr_stop, done, busy}), 64'(4'b1100));

        // Table writes while busy are dropped.
        cyc(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1'b1, '0, N'(32'hDEAD));
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        checkOutput("lock_val", 64'(tmr_match_val0), 64'(100));
        cyc(0, 1, 0, 0, 0);

        // Reset in the middle of a run.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);
        checkOutput("rst_state", 64'({busy, tmr_match0_en, tmr_stop, seq_idx}), 64'(0));

        for (int c = 0; c < 3000; c++) begin
            if (mAge == 0 && $urandom_range(0, 3) == 0) begin
                cfg_last_idx = IW'($urandom);
                cfg_loop     = 1'($urandom);
            end
            applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0,
                          $urandom_range(0, 300) == 0, $urandom_range(0, 3) == 0,
                          IW'($urandom), N'($urandom));
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/timer_sched_ctrl.md
# timer_sched_ctrl

Compare-schedule sequencer for the n-bit system timer. It holds a small table of absolute match values and drives the timer's rst/start/stop control pulses and match-0 compare value. It then walks the table one entry per match-0 event, so a single timer produces a programmed train of events. It sits between the SFR/bus side and the timer's control and match inputs, and consumes the timer's match0 and ovf event pulses.

## Interface
- DATA_WIDTH, 32, SFR/bus data width
- N, 32, timer resolution; width of table entries and match value
- DEPTH, 8, schedule table entries (power of two, ≥2)
- IW, $clog2(DEPTH), index width (derived, not overridden)
- sys_clk  input  1  system clock; the only clock
- sys_rst  input  1  synchronous, active-high reset
- cfg_wr_en  input  1  table write strobe
- cfg_wr_idx  input  IW  table write index
- cfg_wr_data  input  N  absolute match value to store
- cfg_last_idx  input  IW  index of final active entry
- cfg_loop  input  1  1: wrap to entry 0 after last entry
- cmd_go  input  1  start-sequence pulse
- cmd_abort  input  1  abort pulse
- tmr_match0_event  input  1  timer match-0 event pulse
- tmr_ovf_event  input  1  timer overflow event pulse
- tmr_rst  output  1  timer reset pulse
- tmr_start  output  1  timer start pulse
- tmr_stop  output  1  timer stop pulse
- tmr_match_val0  output  N  compare value to timer
- tmr_match0_en  output  1  match-0 event enable to timer
- evt_out  output  1  one pulse per serviced schedule entry
- done  output  1  sequence-complete pulse
- err_ovf  output  1  overflow-before-match pulse
- busy  output  1  state ≠ IDLE
- seq_idx  output  IW  current table index
- evt_cnt  output  N  serviced-event counter (see Configuration)

## Operation
- States: IDLE, ARM, RUN.
- Reset values:
  - State: IDLE.
  - All pulse outputs, busy, tmr_match0_en: 0.
  - seq_idx, tmr_match_val0, evt_cnt: 0.
  - Table contents are not reset.
- Table writes:
  - Accepted only in IDLE. A write in any other state is dropped.
  - A write takes effect at the next edge.
- IDLE:
  - cmd_go moves to ARM.
  - seq_idx←0.
  - tmr_match_val0←table[0].
- ARM:
  - Lasts one cycle with tmr_rst=1.
  - Then moves to RUN with tmr_start=1 for the first RUN cycle.
  - tmr_match0_en=1 from ARM until return to IDLE.
- RUN, on tmr_match0_event:
  - evt_out=1 on the next cycle.
  - If seq_idx<cfg_last_idx: seq_idx+1, and tmr_match_val0←table[seq_idx+1] on the same edge.
  - If seq_idx==cfg_last_idx and cfg_loop=1: tmr_rst pulse, seq_idx←0, tmr_match_val0←table[0]; stay in RUN.
  - If seq_idx==cfg_last_idx and cfg_loop=0: tmr_stop and done pulse, go to IDLE.
- RUN, on tmr_ovf_event: err_ovf and tmr_stop pulse, go to IDLE, no done.
- cmd_abort in ARM or RUN: tmr_stop pulse, go to IDLE; no done, no evt_out.
- cmd_abort in IDLE: ignored.
- Priority within one cycle: sys_rst > cmd_abort > tmr_ovf_event > tmr_match0_event.
- cmd_go while busy: ignored.
- Events arriving in IDLE or ARM are ignored.
- cfg_last_idx and cfg_loop are sampled live. Changing them while busy is legal and takes effect at the next match.

## Timing
- Cycle 0: cmd_go high.
- Cycle 1: ARM, tmr_rst=1, busy=1.
- Cycle 2: RUN, tmr_start=1.
- Match serviced at edge k:
  - evt_out, seq_idx, and tmr_match_val0 all updated at k.
  - evt_out high during cycle k only.
- done, err_ovf, and tmr_stop are registered single-cycle pulses.
- busy is 0 in the same cycle the pulses appear.
- Back-to-back match events on consecutive cycles are each serviced; there is no stall.
- sys_rst mid-sequence: all outputs return to reset values at the next edge, and no tmr_stop is issued.
- seq_idx arithmetic wraps modulo DEPTH. cfg_last_idx=DEPTH-1 is legal.

## Configuration
- TMR_SCHED_EVT_CNT_EN defined:
  - evt_cnt counts evt_out pulses.
  - Cleared on cmd_go acceptance.
  - Saturates at 2^N−1 and is held in IDLE.
- Macro undefined: evt_cnt is tied to 0 and no counter logic is built.

## Test plan
- One-shot: table={100,200,300}, last_idx=2, loop=0.
  - Stimulus: go, then match events on 3 separate cycles.
  - Required: evt_out ×3; tmr_match_val0 sequence 100→200→300; done=1 with tmr_stop=1 after the third event; busy=0.
- Loop: same table with loop=1 and 7 match events.
  - Required: seq_idx sequence 0,1,2,0,1,2,0,1.
  - Required: a tmr_rst pulse after each idx-2 event; no done.
  - With the macro defined: evt_cnt=7.
- Abort vs. match: assert cmd_abort and tmr_match0_event in the same RUN cycle.
  - Required: tmr_stop=1; evt_out=0; done=0; next state IDLE.
- Overflow: in RUN at seq_idx=1, pulse tmr_ovf_event.
  - Required: err_ovf=1 and tmr_stop=1; done=0; busy=0.
- Write lockout: while busy, write idx0=0xDEAD, then finish the sequence and go again.
  - Required: tmr_match_val0 in ARM still equals the original table[0].
- Reset mid-RUN: assert sys_rst.
  - Required: next cycle busy=0, seq_idx=0, tmr_match0_en=0, all pulses 0.
